// File: rtl/countdown_timer_pkg.sv
// Shared clock-datapath types: time field, countdown state and field clamp.
package countdown_timer_pkg;

   localparam int unsigned FIELD_W = 6;

   typedef logic [FIELD_W-1:0] time_field_t;

   localparam time_field_t SEC_MAX = 6'd59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } cd_state_t;

   // Saturate a time field at its upper limit.
   function automatic time_field_t clamp_field(input time_field_t v, input time_field_t lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// 0..59 down-counter with parallel load and a borrow-out raised when it wraps 0 -> 59.
module bcd_down_digit
   import countdown_timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  time_field_t load_val,
   input  logic        dec,
   output time_field_t value,
   output logic        borrow_c
);

   // Counter register: load has priority over decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec) begin
         value <= (value == '0) ? SEC_MAX : value - FIELD_W'(1);
      end
   end

   // Borrow into the next field when a decrement wraps from zero.
   assign borrow_c = dec && !load && (value == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: FSM, preset register, load clamp and expiry detection.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (reload preset on expiry, stay running).
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned MAX_MIN = 59
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       load,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   input  logic       pause,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       expired,
   output logic       done
);

   localparam time_field_t MIN_LIM = FIELD_W'(MAX_MIN);

   cd_state_t   state, state_nxt;
   time_field_t preset_min, preset_sec;
   time_field_t clamp_min_c, clamp_sec_c;
   time_field_t ld_min_c, ld_sec_c;
   logic        at_one_c, nonzero_c, preset_nz_c;
   logic        ld_c, reload_c, sec_dec_c, sec_borrow_c;
   logic        running_nxt, done_nxt, expired_nxt;

   assign clamp_min_c = clamp_field(load_min, MIN_LIM);
   assign clamp_sec_c = clamp_field(load_sec, SEC_MAX);
   assign at_one_c    = (minutes == '0) && (seconds == FIELD_W'(1));
   assign nonzero_c   = (minutes != '0) || (seconds != '0);
   assign preset_nz_c = (preset_min != '0) || (preset_sec != '0);

   // State register together with the registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= running_nxt;
         done    <= done_nxt;
         expired <= expired_nxt;
      end
   end

   // Next-state logic; priority load > pause > start > tick.
   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:   if (!pause && start && nonzero_c) state_nxt = RUN;
            RUN: begin
               if (pause) begin
                  state_nxt = PAUSED;
               end else if (tick && at_one_c) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  state_nxt = preset_nz_c ? RUN : DONE;
`else
                  state_nxt = DONE;
`endif
               end
            end
            PAUSED: if (!pause && start) state_nxt = RUN;
            DONE:   state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath controls and next values of the registered status outputs.
   always_comb begin
      ld_c        = 1'b0;
      reload_c    = 1'b0;
      sec_dec_c   = 1'b0;
      expired_nxt = 1'b0;
      if (load) begin
         ld_c = 1'b1;
      end else if ((state == RUN) && !pause && tick) begin
         if (at_one_c) begin
            expired_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (preset_nz_c) reload_c = 1'b1;
            else             sec_dec_c = 1'b1;
`else
            sec_dec_c = 1'b1;
`endif
         end else begin
            sec_dec_c = 1'b1;
         end
      end
      ld_min_c    = reload_c ? preset_min : clamp_min_c;
      ld_sec_c    = reload_c ? preset_sec : clamp_sec_c;
      running_nxt = (state_nxt == RUN);
      done_nxt    = (state_nxt == DONE);
   end

   // Preset register captures the clamped load value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         preset_min <= '0;
         preset_sec <= '0;
      end else if (ld_c) begin
         preset_min <= clamp_min_c;
         preset_sec <= clamp_sec_c;
      end
   end

   // Seconds field; its borrow steps the minutes field.
   bcd_down_digit u_sec (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld_c | reload_c),
      .load_val (ld_sec_c),
      .dec      (sec_dec_c),
      .value    (seconds),
      .borrow_c (sec_borrow_c)
   );

   // Minutes field: load or decrement on seconds borrow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         minutes <= '0;
      end else if (ld_c | reload_c) begin
         minutes <= ld_min_c;
      end else if (sec_borrow_c) begin
         minutes <= minutes - FIELD_W'(1);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: total-seconds model plus directed literal checks.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_min = '0;
   logic [5:0] load_sec = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [5:0] minutes, seconds;
   logic       running, expired, done;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model: remaining time as total seconds; mode 0 idle, 1 run, 2 paused, 3 done.
   int m_tot  = 0;
   int m_pre  = 0;
   int m_mode = 0;
   bit m_exp  = 1'b0;

   countdown_timer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (load),
      .load_min (load_min),
      .load_sec (load_sec),
      .start    (start),
      .pause    (pause),
      .minutes  (minutes),
      .seconds  (seconds),
      .running  (running),
      .expired  (expired),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model advanced on each rising edge from the sampled inputs.
   always @(posedge clk) begin
      int lm, ls;
      m_exp = 1'b0;
      if (!rst_n) begin
         m_tot = 0; m_pre = 0; m_mode = 0;
      end else if (load) begin
         lm = (int'(load_min) > 59) ? 59 : int'(load_min);
         ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
         m_tot = lm * 60 + ls;
         m_pre = m_tot;
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (!pause && start && m_tot != 0) m_mode = 1;
            1: begin
               if (pause) m_mode = 2;
               else if (tick) begin
                  m_tot = m_tot - 1;
                  if (m_tot == 0) begin
                     m_exp = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     if (m_pre != 0) m_tot = m_pre;
                     else            m_mode = 3;
`else
                     m_mode = 3;
`endif
                  end
               end
            end
            2: if (!pause && start) m_mode = 1;
            default: ;
         endcase
      end
   end

   // Compare DUT against the model every cycle once reset has settled.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_minutes", int'(minutes), m_tot / 60);
         chk("cmp_seconds", int'(seconds), m_tot % 60);
         chk("cmp_running", int'(running), int'(m_mode == 1));
         chk("cmp_done",    int'(done),    int'(m_mode == 3));
         chk("cmp_expired", int'(expired), int'(m_exp));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int m, input int s);
      load = 1'b1; load_min = 6'(m); load_sec = 6'(s);
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1; step(); pause = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; step(); tick = 1'b0; step();
      end
   endtask

   task automatic chk_time(input string name, input int m, input int s);
      chk({name, "_min"}, int'(minutes), m);
      chk({name, "_sec"}, int'(seconds), s);
   endtask

   initial begin
      step(); step();
      chk_time("reset", 0, 0);
      chk("reset_running", int'(running), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_expired", int'(expired), 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Reset in the middle of a run.
      do_load(2, 30);
      do_start();
      run_ticks(3);
      chk_time("run3", 2, 27);
      chk("run3_running", int'(running), 1);
      rst_n = 1'b0; tick = 1'b1; step(); tick = 1'b0; rst_n = 1'b1;
      chk_time("midreset", 0, 0);
      chk("midreset_running", int'(running), 0);
      chk("midreset_done", int'(done), 0);
      do_start();
      chk("zero_after_reset_running", int'(running), 0);

      // Borrow from minutes, then run to expiry.
      do_load(1, 0);
      do_start();
      run_ticks(1);
      chk_time("borrow", 0, 59);
      run_ticks(58);
      chk_time("at_one", 0, 1);
      tick = 1'b1; step(); tick = 1'b0;
      chk("expiry_pulse", int'(expired), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      chk_time("expiry_reload", 1, 0);
      chk("expiry_running", int'(running), 1);
      chk("expiry_done", int'(done), 0);
`else
      chk_time("expiry_zero", 0, 0);
      chk("expiry_running", int'(running), 0);
      chk("expiry_done", int'(done), 1);
`endif
      step();
      chk("expiry_pulse_end", int'(expired), 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      chk("done_level", int'(done), 1);
      do_start();
      chk("done_ignores_start", int'(running), 0);
      chk_time("done_hold", 0, 0);
`endif

      // Pause and resume.
      do_load(0, 10);
      chk("load_clears_done", int'(done), 0);
      do_start();
      run_ticks(3);
      chk_time("pre_pause", 0, 7);
      do_pause();
      run_ticks(5);
      chk_time("paused_hold", 0, 7);
      chk("paused_running", int'(running), 0);
      do_start();
      run_ticks(2);
      chk_time("resumed", 0, 5);

      // Priority: load beats tick; pause beats tick; start+tick does not decrement.
      load = 1'b1; tick = 1'b1; load_min = 6'd0; load_sec = 6'd40;
      step();
      load = 1'b0; tick = 1'b0;
      chk_time("load_tick", 0, 40);
      chk("load_tick_running", int'(running), 0);
      do_start();
      pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
      chk_time("pause_tick", 0, 40);
      chk("pause_tick_running", int'(running), 0);
      start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
      chk_time("start_tick", 0, 40);
      chk("start_tick_running", int'(running), 1);
      run_ticks(1);
      chk_time("after_start_tick", 0, 39);

      // Clamp and zero start.
      do_load(63, 62);
      chk_time("clamp", 59, 59);
      do_start();
      run_ticks(2);
      chk_time("clamp_run", 59, 57);
      do_load(0, 0);
      do_start();
      chk("zero_start_running", int'(running), 0);
      chk_time("zero_start", 0, 0);

      // Short preset expiring on back-to-back ticks.
      do_load(0, 2);
      do_start();
      tick = 1'b1; step(); step(); tick = 1'b0;
      chk("short_expired", int'(expired), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      chk_time("short_reload", 0, 2);
      chk("short_running", int'(running), 1);
      chk("short_done", int'(done), 0);
`else
      chk_time("short_zero", 0, 0);
      chk("short_running", int'(running), 0);
      chk("short_done", int'(done), 1);
`endif
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
